// File: rtl/change_dispenser.sv
// change_dispenser: greedy dime-then-nickel change splitter, one eject pulse per coin, then a one-cycle inventory subtract.
// Optional macro CHANGE_PARTIAL_EN: dispense what inventory allows and report the remainder as shortfall.
module change_dispenser #(
  parameter int AMT_W     = 6,
  parameter int CNT_W     = 8,
  parameter int PULSE_GAP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [CNT_W-1:0] nickel_avail,
  input  logic [CNT_W-1:0] dime_avail,
  output logic [CNT_W-1:0] sub_nickel,
  output logic [CNT_W-1:0] sub_dime,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AMT_W-1:0] shortfall
);

  localparam int MW    = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
  localparam int GAP_W = $clog2(PULSE_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_DIME,
    S_NICKEL,
    S_COMMIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   amount_q, amount_d;
  logic [AMT_W-1:0]   dimes_q, dimes_d;
  logic [AMT_W-1:0]   nick_q, nick_d;
  logic [AMT_W-1:0]   left_q, left_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef CHANGE_PARTIAL_EN
  logic [AMT_W-1:0]   short_q, short_d;
`endif

  logic [MW-1:0] amt_w, half_w, davail_w, navail_w;
  logic [MW-1:0] dimes_w, rem_w, nick_w;
  logic          fits_w;
  logic          last_gap_w;

  // Split arithmetic is done one bit wider than either operand so nothing truncates.
  assign amt_w    = MW'(amount_q);
  assign half_w   = MW'(amount_q >> 1);
  assign davail_w = MW'(dime_avail);
  assign navail_w = MW'(nickel_avail);
  assign dimes_w  = (half_w < davail_w) ? half_w : davail_w;
  assign rem_w    = amt_w - (dimes_w << 1);
  assign fits_w   = (rem_w <= navail_w);
`ifdef CHANGE_PARTIAL_EN
  assign nick_w   = fits_w ? rem_w : navail_w;
`else
  assign nick_w   = rem_w;
`endif

  assign last_gap_w = (gap_q == GAP_W'(PULSE_GAP - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      amount_q <= '0;
      dimes_q  <= '0;
      nick_q   <= '0;
      left_q   <= '0;
      gap_q    <= '0;
`ifdef CHANGE_PARTIAL_EN
      short_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      amount_q <= amount_d;
      dimes_q  <= dimes_d;
      nick_q   <= nick_d;
      left_q   <= left_d;
      gap_q    <= gap_d;
`ifdef CHANGE_PARTIAL_EN
      short_q  <= short_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    dimes_d    = dimes_q;
    nick_d     = nick_q;
    left_d     = left_q;
    gap_d      = gap_q;
`ifdef CHANGE_PARTIAL_EN
    short_d    = short_q;
`endif
    sub_nickel = '0;
    sub_dime   = '0;
    nickel_out = 1'b0;
    dime_out   = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    fail       = 1'b0;
    shortfall  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          amount_d = amount;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        dimes_d = AMT_W'(dimes_w);
        nick_d  = AMT_W'(nick_w);
        gap_d   = '0;
`ifdef CHANGE_PARTIAL_EN
        short_d = fits_w ? '0 : AMT_W'(rem_w - navail_w);
        if (dimes_w != '0) begin
`else
        if (!fits_w) begin
          state_d = S_FAIL;
        end else if (dimes_w != '0) begin
`endif
          state_d = S_DIME;
          left_d  = AMT_W'(dimes_w);
        end else if (nick_w != '0) begin
          state_d = S_NICKEL;
          left_d  = AMT_W'(nick_w);
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_DIME: begin
        dime_out = (gap_q == '0);
        if (last_gap_w) begin
          gap_d  = '0;
          left_d = left_q - AMT_W'(1);
          if (left_q == AMT_W'(1)) begin
            if (nick_q != '0) begin
              state_d = S_NICKEL;
              left_d  = nick_q;
            end else begin
              state_d = S_COMMIT;
            end
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_NICKEL: begin
        nickel_out = (gap_q == '0);
        if (last_gap_w) begin
          gap_d  = '0;
          left_d = left_q - AMT_W'(1);
          if (left_q == AMT_W'(1)) begin
            state_d = S_COMMIT;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_COMMIT: begin
        sub_dime   = CNT_W'(dimes_q);
        sub_nickel = CNT_W'(nick_q);
        state_d    = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
`ifdef CHANGE_PARTIAL_EN
        // A nonzero remainder only arises from a partial dispense.
        fail      = (short_q != '0);
        shortfall = short_q;
`endif
        state_d = S_IDLE;
      end

      S_FAIL: begin
        done      = 1'b1;
        fail      = 1'b1;
        shortfall = amount_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed cases plus randomized requests against a cycle-timed arithmetic model.
module tb_change_dispenser;
  localparam int AMT_W = 6;
  localparam int CNT_W = 8;
  localparam int G     = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic [CNT_W-1:0] nickel_avail = '0;
  logic [CNT_W-1:0] dime_avail = '0;
  logic [CNT_W-1:0] sub_nickel;
  logic [CNT_W-1:0] sub_dime;
  logic             nickel_out;
  logic             dime_out;
  logic             busy;
  logic             done;
  logic             fail;
  logic [AMT_W-1:0] shortfall;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_GAP(G)) dut (
    .clock(clock), .reset(reset), .start(start), .amount(amount),
    .nickel_avail(nickel_avail), .dime_avail(dime_avail),
    .sub_nickel(sub_nickel), .sub_dime(sub_dime),
    .nickel_out(nickel_out), .dime_out(dime_out),
    .busy(busy), .done(done), .fail(fail), .shortfall(shortfall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
    check({tag, ".fail"},       32'(fail),       32'd0);
    check({tag, ".dime_out"},   32'(dime_out),   32'd0);
    check({tag, ".nickel_out"}, 32'(nickel_out), 32'd0);
    check({tag, ".sub_dime"},   32'(sub_dime),   32'd0);
    check({tag, ".sub_nickel"}, 32'(sub_nickel), 32'd0);
    check({tag, ".shortfall"},  32'(shortfall),  32'd0);
  endtask

  // One request: the expected cycle-by-cycle trace is derived from the coin arithmetic alone.
  task automatic run_txn(input int a, input int da, input int na, input bit hold);
    int  d, nk, rem, sh, t, off, idx;
    bit  fl, cm, pulse;
    d   = ((a / 2) < da) ? (a / 2) : da;
    rem = a - 2 * d;
    if (rem <= na) begin
      nk = rem; sh = 0; fl = 1'b0; cm = 1'b1;
    end else begin
`ifdef CHANGE_PARTIAL_EN
      nk = na; sh = rem - na; fl = 1'b1; cm = 1'b1;
`else
      d = 0; nk = 0; sh = a; fl = 1'b1; cm = 1'b0;
`endif
    end
    t = cm ? (3 + (d + nk) * G) : 2;

    @(negedge clock);
    start        = 1'b1;
    amount       = AMT_W'(a);
    dime_avail   = CNT_W'(da);
    nickel_avail = CNT_W'(na);
    for (int n = 1; n <= t; n++) begin
      @(negedge clock);
      off   = n - 2;
      idx   = (off >= 0) ? off / G : 0;
      pulse = cm && (off >= 0) && (off < (d + nk) * G) && (off % G == 0);
      check("busy",       32'(busy),       32'd1);
      check("done",       32'(done),       32'(n == t));
      check("fail",       32'(fail),       32'(n == t && fl));
      check("dime_out",   32'(dime_out),   32'(pulse && idx < d));
      check("nickel_out", 32'(nickel_out), 32'(pulse && idx >= d));
      check("sub_dime",   32'(sub_dime),   (cm && n == t - 1) ? 32'(d)  : 32'd0);
      check("sub_nickel", 32'(sub_nickel), (cm && n == t - 1) ? 32'(nk) : 32'd0);
      if (n == t) check("shortfall", 32'(shortfall), 32'(sh));
      if (hold && n < t) begin
        amount = AMT_W'($urandom);
      end else begin
        start = 1'b0;
      end
      // Inventory is only sampled during the calculation cycle (n == 1).
      if (n >= 2) begin
        dime_avail   = CNT_W'($urandom);
        nickel_avail = CNT_W'($urandom);
      end
    end
    @(negedge clock);
    check("post.busy", 32'(busy), 32'd0);
    check("post.done", 32'(done), 32'd0);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("idle");

    run_txn(7, 5, 5, 1'b0);
    run_txn(7, 1, 5, 1'b0);
    run_txn(7, 1, 3, 1'b0);
    run_txn(0, 9, 9, 1'b0);
    run_txn(63, 40, 40, 1'b0);
    run_txn(6, 0, 6, 1'b0);

    // Reset during the second dime pulse of a 4-nickel request.
    @(negedge clock);
    start = 1'b1; amount = AMT_W'(4); dime_avail = CNT_W'(10); nickel_avail = CNT_W'(10);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.second_dime", 32'(dime_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("rst.abort");
    repeat (3) begin
      @(negedge clock);
      check("rst.no_commit_d", 32'(sub_dime),   32'd0);
      check("rst.no_commit_n", 32'(sub_nickel), 32'd0);
      check("rst.busy",        32'(busy),       32'd0);
    end
    reset = 1'b1;
    run_txn(4, 10, 10, 1'b0);

    // Start held high with a changing amount must not disturb the request in flight.
    run_txn(9, 3, 4, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(63, 0)), int'($urandom_range(35, 0)),
              int'($urandom_range(20, 0)), bit'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
